// File: rtl/cba_array_sequencer.sv
// Sequencer for the CBA literal/phase register array. Loads a tableau row by
// row, applies single-qubit Clifford/Pauli conjugations by rotating the array
// one full turn and substituting at the target column, then unloads the rows
// in load order.
module cba_array_sequencer #(
  parameter int num_qubit = 4,
  parameter int CW        = $clog2(num_qubit)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*num_qubit-1:0] in_literals,
  input  logic                   in_phase,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [CW-1:0]          cmd_qubit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*num_qubit-1:0] out_literals,
  output logic                   out_phase,
  output logic                   busy,
  input  logic [2*num_qubit-1:0] arr_left_out,
  input  logic [2*num_qubit-1:0] arr_literals_out,
  input  logic                   arr_phase_out,
  output logic                   arr_ld_literal,
  output logic                   arr_shift_rotate,
  output logic [2*num_qubit-1:0] arr_literals_in,
  output logic                   arr_phase_in,
  output logic [num_qubit-1:0]   arr_ld_phase,
  output logic                   arr_shift_toggle,
  output logic                   arr_rotate_update,
  output logic [2*num_qubit-1:0] arr_update_literal
);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_CMD    = 2'd1;
  localparam logic [1:0] S_ROTATE = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;

  localparam logic [CW-1:0] LAST = CW'(num_qubit - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] row_cnt_q, row_cnt_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [CW-1:0] qubit_q, qubit_d;
  logic [1:0]    op_q, op_d;

  logic                   col_hit;
  logic [2*num_qubit-1:0] conj_lit;
  logic [num_qubit-1:0]   conj_tog;

  // Conjugate one literal (00=I, 01=X, 10=Z, 11=Y); returns {toggle, literal}.
  function automatic logic [2:0] conj_f(input logic [1:0] op, input logic [1:0] lit);
    logic [2:0] r;
    r = {1'b0, lit};
    case (op)
      2'd0: case (lit)                      // H
              2'b01: r = 3'b0_10;
              2'b10: r = 3'b0_01;
              2'b11: r = 3'b1_11;
              default: r = 3'b0_00;
            endcase
      2'd1: case (lit)                      // S
              2'b01: r = 3'b0_11;
              2'b11: r = 3'b1_01;
              default: r = {1'b0, lit};
            endcase
      2'd2: r = {lit[1], lit};              // X: Z and Y anticommute
      default: r = {lit[0], lit};           // Z: X and Y anticommute
    endcase
    return r;
  endfunction

  // Per-row conjugation of the literal currently sitting in the left column.
  for (genvar gi = 0; gi < num_qubit; gi++) begin : g_conj
    logic [2:0] res;
    assign res                    = conj_f(op_q, arr_left_out[2*gi+1:2*gi]);
    assign conj_lit[2*gi+1:2*gi]  = res[1:0];
    assign conj_tog[gi]           = res[2];
  end

  // Out-of-range qubits never match, so the command is a plain full rotation.
  assign col_hit = (col_cnt_q == qubit_q) && (32'(qubit_q) < num_qubit);

  // Moore handshake outputs and the unload data path.
  assign in_ready     = (state_q == S_LOAD);
  assign cmd_ready    = (state_q == S_CMD);
  assign out_valid    = (state_q == S_UNLOAD);
  assign busy         = (state_q != S_LOAD);
  assign out_literals = arr_literals_out;
  assign out_phase    = arr_phase_out;

  // Next-state logic and array control decode.
  always_comb begin
    state_d            = state_q;
    row_cnt_d          = row_cnt_q;
    col_cnt_d          = col_cnt_q;
    qubit_d            = qubit_q;
    op_d               = op_q;
    arr_ld_literal     = 1'b0;
    arr_shift_rotate   = 1'b0;
    arr_literals_in    = '0;
    arr_phase_in       = 1'b0;
    arr_ld_phase       = '0;
    arr_shift_toggle   = 1'b0;
    arr_rotate_update  = 1'b0;
    arr_update_literal = '0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          arr_ld_literal  = 1'b1;
          arr_literals_in = in_literals;
          arr_phase_in    = in_phase;
          arr_ld_phase    = '1;
          if (row_cnt_q == LAST) begin
            row_cnt_d = '0;
            state_d   = S_CMD;
          end else begin
            row_cnt_d = row_cnt_q + CW'(1);
          end
        end
      end
      S_CMD: begin
        if (cmd_valid) begin
          if (cmd_op <= 3'd3) begin
            op_d      = cmd_op[1:0];
            qubit_d   = cmd_qubit;
            col_cnt_d = '0;
            state_d   = S_ROTATE;
          end else if (cmd_op == 3'd4) begin
            row_cnt_d = '0;
            state_d   = S_UNLOAD;
          end
        end
      end
      S_ROTATE: begin
        arr_ld_literal   = 1'b1;
        arr_shift_rotate = 1'b1;
        if (col_hit) begin
          arr_rotate_update  = 1'b1;
          arr_update_literal = conj_lit;
          arr_ld_phase       = conj_tog;
          arr_shift_toggle   = 1'b1;
        end
        if (col_cnt_q == LAST) begin
          col_cnt_d = '0;
          state_d   = S_CMD;
        end else begin
          col_cnt_d = col_cnt_q + CW'(1);
        end
      end
      default: begin
        if (out_ready) begin
          arr_ld_literal = 1'b1;
          arr_ld_phase   = '1;
          if (row_cnt_q == LAST) begin
            row_cnt_d = '0;
            state_d   = S_LOAD;
          end else begin
            row_cnt_d = row_cnt_q + CW'(1);
          end
        end
      end
    endcase
  end

  // State and counter registers; reset aborts whatever phase is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      qubit_q   <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      qubit_q   <= qubit_d;
      op_q      <= op_d;
    end
  end

endmodule

// File: tb/tb_cba_array_sequencer.sv
// Directed bench for cba_array_sequencer with a behavioural model of the
// literal/phase register array attached to the arr_* ports.
module tb_cba_array_sequencer;

  localparam int N  = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*N-1:0]  in_literals = '0;
  logic            in_phase = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [2:0]      cmd_op = '0;
  logic [CW-1:0]   cmd_qubit = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*N-1:0]  out_literals;
  logic            out_phase;
  logic            busy;
  logic [2*N-1:0]  arr_left_out;
  logic [2*N-1:0]  arr_literals_out;
  logic            arr_phase_out;
  logic            arr_ld_literal;
  logic            arr_shift_rotate;
  logic [2*N-1:0]  arr_literals_in;
  logic            arr_phase_in;
  logic [N-1:0]    arr_ld_phase;
  logic            arr_shift_toggle;
  logic            arr_rotate_update;
  logic [2*N-1:0]  arr_update_literal;

  cba_array_sequencer #(.num_qubit(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_literals(in_literals), .in_phase(in_phase),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_qubit(cmd_qubit),
    .out_valid(out_valid), .out_ready(out_ready), .out_literals(out_literals), .out_phase(out_phase),
    .busy(busy),
    .arr_left_out(arr_left_out), .arr_literals_out(arr_literals_out), .arr_phase_out(arr_phase_out),
    .arr_ld_literal(arr_ld_literal), .arr_shift_rotate(arr_shift_rotate),
    .arr_literals_in(arr_literals_in), .arr_phase_in(arr_phase_in), .arr_ld_phase(arr_ld_phase),
    .arr_shift_toggle(arr_shift_toggle), .arr_rotate_update(arr_rotate_update),
    .arr_update_literal(arr_update_literal)
  );

  always #5 clk = ~clk;

  // Array model: row 0 is the top, row N-1 the bottom; column 0 (qubit 0) is the left column.
  logic [2*N-1:0] m_row [N];
  logic           m_ph  [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_left
    assign arr_left_out[2*gi+1:2*gi] = m_row[gi][1:0];
  end
  assign arr_literals_out = m_row[N-1];
  assign arr_phase_out    = m_ph[N-1];

  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      if (arr_ld_literal) begin
        if (arr_shift_rotate)
          m_row[r] <= {(arr_rotate_update ? arr_update_literal[2*r+:2] : m_row[r][1:0]),
                       m_row[r][2*N-1:2]};
        else
          m_row[r] <= (r == 0) ? arr_literals_in : m_row[r-1];
      end
      if (arr_ld_phase[r]) begin
        if (arr_shift_toggle) m_ph[r] <= ~m_ph[r];
        else                  m_ph[r] <= (r == 0) ? arr_phase_in : m_ph[r-1];
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  logic [2*N-1:0] ld_lit [N];
  logic           ld_ph  [N];
  logic [2*N-1:0] ex_lit [N];
  logic           ex_ph  [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] arr_bus();
    return 32'({arr_ld_literal, arr_shift_rotate, arr_literals_in, arr_phase_in, arr_ld_phase,
                arr_shift_toggle, arr_rotate_update, arr_update_literal});
  endfunction

  task automatic load_tableau(input string tag);
    for (int i = 0; i < N; i++) begin
      in_valid    = 1'b1;
      in_literals = ld_lit[i];
      in_phase    = ld_ph[i];
      #1;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      if (i == 0) chk({tag, "_ld_en"}, 32'({arr_ld_literal, arr_ld_phase}), 32'h1F);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk({tag, "_to_cmd"}, 32'({cmd_ready, busy, in_ready}), 32'b110);
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [CW-1:0] q);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_qubit = q;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [CW-1:0] q);
    int cnt;
    send_cmd(op, q);
    cnt = 0;
    while (arr_ld_literal && arr_shift_rotate && cnt < 20) begin
      cnt++;
      tick();
    end
    chk({tag, "_rot_cycles"}, 32'(cnt), 32'd4);
    chk({tag, "_back_cmd"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic unload_beats(input string tag);
    for (int i = 0; i < N; i++) begin
      out_ready = 1'b1;
      #1;
      chk($sformatf("%s_beat%0d_valid", tag, i), 32'(out_valid), 32'd1);
      chk($sformatf("%s_beat%0d_lit", tag, i), 32'(out_literals), 32'(ex_lit[i]));
      chk($sformatf("%s_beat%0d_ph", tag, i), 32'(out_phase), 32'(ex_ph[i]));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk({tag, "_to_load"}, 32'({in_ready, busy, out_valid}), 32'b100);
  endtask

  task automatic set_rows(input logic [2*N-1:0] l0, input logic p0, input logic [2*N-1:0] l1, input logic p1,
                          input logic [2*N-1:0] l2, input logic p2, input logic [2*N-1:0] l3, input logic p3);
    ld_lit[0] = l0; ld_ph[0] = p0; ld_lit[1] = l1; ld_ph[1] = p1;
    ld_lit[2] = l2; ld_ph[2] = p2; ld_lit[3] = l3; ld_ph[3] = p3;
  endtask

  task automatic set_exp(input logic [2*N-1:0] l0, input logic p0, input logic [2*N-1:0] l1, input logic p1,
                         input logic [2*N-1:0] l2, input logic p2, input logic [2*N-1:0] l3, input logic p3);
    ex_lit[0] = l0; ex_ph[0] = p0; ex_lit[1] = l1; ex_ph[1] = p1;
    ex_lit[2] = l2; ex_ph[2] = p2; ex_lit[3] = l3; ex_ph[3] = p3;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #1;
    chk("rst_arr_outputs", arr_bus(), 32'd0);
    chk("rst_hs", 32'({busy, cmd_ready, out_valid}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Plain load / unload: rows leave in load order
    set_rows(8'h01, 1'b0, 8'h04, 1'b1, 8'h10, 1'b0, 8'h40, 1'b1);
    set_exp (8'h01, 1'b0, 8'h04, 1'b1, 8'h10, 1'b0, 8'h40, 1'b1);
    load_tableau("pass");
    send_cmd(3'd4, 2'd0);
    unload_beats("pass");

    // H on q1: Y->Y with sign flip, X->Z, Z->X, I untouched
    set_rows(8'h0C, 1'b0, 8'h04, 1'b0, 8'h08, 1'b1, 8'h01, 1'b0);
    set_exp (8'h0C, 1'b1, 8'h08, 1'b0, 8'h04, 1'b1, 8'h01, 1'b0);
    load_tableau("h");
    run_cmd("h", 3'd0, 2'd1);
    send_cmd(3'd4, 2'd0);
    unload_beats("h");

    // S on q0: X->Y, Y->X with sign flip, Z unchanged
    set_rows(8'h01, 1'b0, 8'h03, 1'b0, 8'h02, 1'b1, 8'hFF, 1'b0);
    set_exp (8'h03, 1'b0, 8'h01, 1'b1, 8'h02, 1'b1, 8'hFD, 1'b1);
    load_tableau("s");
    run_cmd("s", 3'd1, 2'd0);
    send_cmd(3'd4, 2'd0);
    unload_beats("s");

    // X then Z on q2: only anticommuting literals flip sign
    set_rows(8'h10, 1'b0, 8'h20, 1'b0, 8'h30, 1'b0, 8'h00, 1'b0);
    set_exp (8'h10, 1'b1, 8'h20, 1'b1, 8'h30, 1'b0, 8'h00, 1'b0);
    load_tableau("xz");
    run_cmd("xz_x", 3'd2, 2'd2);
    run_cmd("xz_z", 3'd3, 2'd2);
    send_cmd(3'd4, 2'd0);
    unload_beats("xz");

    // Backpressure: out_valid held, data stable, no shift while out_ready low
    set_rows(8'h11, 1'b1, 8'h22, 1'b0, 8'h33, 1'b1, 8'h44, 1'b0);
    set_exp (8'h11, 1'b1, 8'h22, 1'b0, 8'h33, 1'b1, 8'h44, 1'b0);
    load_tableau("bp");
    send_cmd(3'd4, 2'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold%0d", i), 32'({out_valid, arr_ld_literal, out_phase, out_literals}),
          32'({1'b1, 1'b0, ex_ph[0], ex_lit[0]}));
      tick();
    end
    unload_beats("bp");

    // NOP stays in CMD with no array activity; qubit 7 wraps to 3 on the
    // 2-bit port, where every row holds I, so the tableau comes back unchanged
    set_rows(8'h3F, 1'b0, 8'h15, 1'b1, 8'h2A, 1'b0, 8'h00, 1'b1);
    set_exp (8'h3F, 1'b0, 8'h15, 1'b1, 8'h2A, 1'b0, 8'h00, 1'b1);
    load_tableau("nop");
    send_cmd(3'd6, 2'd0);
    chk("nop_stay", 32'({cmd_ready, busy}), 32'b11);
    chk("nop_arr_idle", arr_bus(), 32'd0);
    begin
      logic [2:0] q7;
      q7 = 3'd7;
      run_cmd("q7", 3'd2, q7[CW-1:0]);
    end
    send_cmd(3'd4, 2'd0);
    unload_beats("q7");

    // Reset on the 2nd ROTATE cycle aborts immediately
    set_rows(8'h05, 1'b0, 8'h0A, 1'b1, 8'h0F, 1'b0, 8'h50, 1'b1);
    load_tableau("ra");
    send_cmd(3'd0, 2'd0);
    chk("ra_rot1", 32'({arr_ld_literal, arr_shift_rotate}), 32'b11);
    tick();
    rst = 1'b1;
    #1;
    chk("ra_arr_zero", arr_bus(), 32'd0);
    chk("ra_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ra_in_ready", 32'({in_ready, busy}), 32'b10);

    // Fresh tableau after the abort loads and unloads cleanly
    set_rows(8'h81, 1'b1, 8'h42, 1'b0, 8'h24, 1'b1, 8'h18, 1'b0);
    set_exp (8'h81, 1'b1, 8'h42, 1'b0, 8'h24, 1'b1, 8'h18, 1'b0);
    load_tableau("post");
    send_cmd(3'd4, 2'd0);
    unload_beats("post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
